gate_truth_checker: RTL and testbench
=====================================

# gate_truth_checker

Sequential self-checking responder for two-input logic gate DUTs. It drives every input combination onto a DUT's `a`/`b` pins, waits a programmable settle time, samples the DUT's `y` output and compares it against a parameterised truth table. It reports a mismatch count, a per-vector failure mask and a pass flag. It replaces hand-written display-only stimulus and sits beside any gate module (NOR, NAND, XOR, ...) in on-chip or simulation self-test.

## Interface
Parameters:
- `EXPECT`, default `4'b0001` (NOR): expected truth table. Bit index = `{a,b}`, so `EXPECT[i]` is the expected `y` for vector `i`.
- `SETTLE`, default `1`: cycles each vector is held before sampling. Legal range 1..255. Values below 1 are illegal; flag them with a simulation-time error.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: run request, sampled on the rising edge.
- `dut_a` out 1: drive to DUT input `a`.
- `dut_b` out 1: drive to DUT input `b`.
- `dut_y` in 1: DUT output `y`.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: sticky completion flag.
- `pass` out 1: high when `done` is high and `err_count == 0`.
- `err_count` out 3: number of mismatching vectors, range 0..4.
- `fail_mask` out 4: bit `i` set when vector `i` mismatched.

## Operation
- Reset values: state IDLE, `dut_a`=0, `dut_b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_mask`=0. The vector index and settle counter are also 0.
- All outputs are registered. `pass` is decoded from registered state, with no combinational path from `dut_y`.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- **IDLE**
  - `start`=1 moves to DRIVE.
  - On that transition: index=0, `{dut_a,dut_b}`=2'b00, `err_count`=0, `fail_mask`=0, `done`=0.
- **DRIVE**
  - `{dut_a,dut_b}` = index.
  - The settle counter counts SETTLE-1 down to 0, one DRIVE cycle per count.
  - When the count reaches 0, move to SAMPLE.
- **SAMPLE** (one cycle). At the exiting edge, compare `dut_y` with `EXPECT[index]`.
  - A mismatch sets `fail_mask[index]` and increments `err_count`.
  - An X or Z on `dut_y` counts as a mismatch (case inequality in simulation).
  - If index==3, go to DONE. Otherwise increment index, drive the new vector on the same edge, reload the settle counter and return to DRIVE.
- **DONE**
  - `done`=1 and `busy`=0.
  - `dut_a`/`dut_b` hold vector 2'b11.
  - `err_count` and `fail_mask` hold until the next start.
  - `start`=1 here restarts exactly as from IDLE: results clear and `done` drops on the same edge.
- `busy` = 1 in DRIVE and SAMPLE only.
- `start` is ignored in DRIVE and SAMPLE. No queuing and no restart.
- Reset asserted mid-sweep aborts immediately to reset values. No partial results are retained.
- Vector order is fixed: 00, 01, 10, 11.
- The index is 2 bits. It never wraps past 3, because index==3 in SAMPLE exits to DONE.
- `err_count` cannot overflow, since there are at most 4 increments.

## Timing
- Let edge k be the edge at which `start`=1 is sampled in IDLE or DONE.
- Vector `i` is driven from edge k+i·(SETTLE+1).
- `dut_y` for vector `i` is sampled at edge k+(i+1)·(SETTLE+1), when the next vector is driven.
- The DUT therefore sees each vector stable for SETTLE+1 clock periods before capture.
- `busy` rises at edge k.
- `done` rises and `busy` falls at edge k+4·(SETTLE+1). With SETTLE=1 this is edge k+8.
- `err_count`, `fail_mask` and `pass` are final at the same edge `done` rises.
- Reset is asynchronous: outputs reach reset values without a clock edge. Release is synchronous in effect, since the first `start` is honoured at the first rising edge after `rst` deasserts.

## Test plan
- **Reset:** assert `rst` mid-cycle with no clock. All outputs go to reset values immediately. Assert again during DRIVE of vector 2: same result, and `busy`=0.
- **Correct NOR, SETTLE=1, EXPECT=4'b0001:** pulse `start` at edge k.
  - `{dut_a,dut_b}` steps 00, 01, 10, 11 at edges k, k+2, k+4, k+6.
  - `done`=1 at k+8, with `err_count`=0, `fail_mask`=0 and `pass`=1.
- **OR gate with NOR EXPECT:** all four vectors mismatch. Result: `err_count`=4, `fail_mask`=4'b1111, `pass`=0.
- **`dut_y` stuck at 0 with NOR EXPECT:** only vector 00 fails. Result: `err_count`=1, `fail_mask`=4'b0001. Then tie `dut_y` to X and rerun: `err_count`=4.
- **Handshake:** pulse `start` again at k+3 during the sweep. It is ignored and `done` still rises at k+8. Then pulse `start` in DONE: `done`=0, results clear, and a new sweep begins on that edge.
- **SETTLE=3, correct NOR:** each vector is held 4 cycles. `done` rises at edge k+16 and `pass`=1.

Source files
------------

// File: rtl/gate_truth_checker.sv
// Sweeps the four {a,b} vectors onto a two-input gate under test, samples its y
// after a programmable settle time and scores each vector against EXPECT.
module gate_truth_checker #(
  parameter logic [3:0] EXPECT = 4'b0001,
  parameter int         SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [7:0] RELOAD = 8'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic       miss;

  // Case inequality so an X/Z from the gate under test scores as a mismatch.
  assign miss = (dut_y !== EXPECT[idx]);

  // Both operands are registers, so pass carries no path from dut_y.
  assign pass = done && (err_count == 3'd0);

  always_ff @(posedge clk) begin
    assert (SETTLE >= 1 && SETTLE <= 255)
      else $error("gate_truth_checker: SETTLE=%0d outside legal range 1..255", SETTLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = DRIVE;
      DRIVE:      if (cnt == 8'd0) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = (idx == 2'd3) ? DONE : DRIVE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= 2'd0;
      cnt       <= 8'd0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= 3'd0;
      fail_mask <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx          <= 2'd0;
            cnt          <= RELOAD;
            {dut_a, dut_b} <= 2'b00;
            busy         <= 1'b1;
            done         <= 1'b0;
            err_count    <= 3'd0;
            fail_mask    <= 4'd0;
          end
        end
        DRIVE: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
        end
        SAMPLE: begin
          if (miss) begin
            fail_mask[idx] <= 1'b1;
            err_count      <= err_count + 3'd1;
          end
          if (idx == 2'd3) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            // The next vector goes out on the same edge that captures this one.
            idx            <= idx + 2'd1;
            {dut_a, dut_b} <= idx + 2'd1;
            cnt            <= RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Drives modelled gates (correct, faulty, random, X) into gate_truth_checker and
// scores its timing and results against a truth-table reference model.
module tb_gate_truth_checker;

  localparam logic [3:0] NOR_TBL = 4'b0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, a1, b1, y1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] mask1;
  logic [3:0] gate_tbl;
  logic       y_x;

  logic       start3, a3, b3, y3, busy3, done3, pass3;
  logic [2:0] err3;
  logic [3:0] mask3;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Gate under test is just a lookup of the table the bench chooses.
  assign y1 = gate_tbl[{a1, b1}];
  assign y3 = ~(a3 | b3);

  gate_truth_checker #(.EXPECT(NOR_TBL), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_b(b1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_mask(mask1)
  );

  gate_truth_checker #(.EXPECT(NOR_TBL), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .dut_a(a3), .dut_b(b3), .dut_y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_mask(mask3)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: a vector fails whenever the gate's response differs from NOR.
  function automatic logic [3:0] model_mask(input logic [3:0] tbl);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (tbl[i] !== NOR_TBL[i]);
    return m;
  endfunction

  // Called at a negedge with the SETTLE=1 checker idle or done; optionally pulses
  // start again so it is sampled at edge k+pulse_at (0 = no extra pulse).
  task automatic sweep1(input logic [3:0] tbl, input string tag, input int pulse_at);
    logic [3:0] exp_mask;
    logic [2:0] exp_err;
    gate_tbl = tbl;
    exp_mask = model_mask(tbl);
    exp_err  = 3'($countones(exp_mask));
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    check({tag, "_clear"}, 16'({err1, mask1}), 16'd0);
    for (int t = 0; t < 8; t++) begin
      check({tag, "_step"}, 16'({busy1, done1, a1, b1}), 16'({2'b10, 2'(t / 2)}));
      start1 = (t + 1 == pulse_at);
      @(posedge clk);
      @(negedge clk);
    end
    start1 = 1'b0;
    check({tag, "_end"}, 16'({busy1, done1, a1, b1}), 16'({2'b01, 2'b11}));
    check({tag, "_err"}, 16'(err1), 16'(exp_err));
    check({tag, "_mask"}, 16'(mask1), 16'(exp_mask));
    check({tag, "_pass"}, 16'(pass1), 16'(exp_mask == 4'd0));
  endtask

  task automatic check_reset1(input string tag);
    check(tag, 16'({busy1, done1, pass1, a1, b1, err1, mask1}), 16'd0);
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; gate_tbl = NOR_TBL; y_x = 1'bx;
    @(negedge clk);
    check_reset1("reset_init");
    check("reset_init3", 16'({busy3, done3, pass3, a3, b3, err3, mask3}), 16'd0);
    rst = 1'b0;
    @(negedge clk);

    sweep1(NOR_TBL, "nor_ok", 0);

    // Asynchronous reset between edges out of DONE.
    #2 rst = 1'b1;
    #1 check_reset1("reset_async_done");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    sweep1(4'b1110, "or_gate", 0);
    sweep1(4'b0000, "stuck0", 0);
    sweep1({4{y_x}}, "y_x", 0);

    // Extra start at k+3 must be ignored; the following sweep restarts from DONE.
    sweep1(NOR_TBL, "handshake", 3);
    sweep1(4'b1110, "restart", 0);

    // Reset while vector 2 is being driven, after two mismatches have been scored.
    gate_tbl = 4'b1110;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_vec2", 16'({busy1, a1, b1, err1}), 16'({1'b1, 2'b10, 3'd2}));
    #2 rst = 1'b1;
    #1 check_reset1("reset_async_drive");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    repeat (6) begin
      logic [3:0] tbl;
      tbl = 4'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sweep1(tbl, "rand", 0);
    end

    // SETTLE=3: each vector is held four cycles, done at k+16.
    start3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
    for (int t = 0; t < 16; t++) begin
      check("settle3_step", 16'({busy3, done3, a3, b3}), 16'({2'b10, 2'(t / 4)}));
      @(posedge clk);
      @(negedge clk);
    end
    check("settle3_end", 16'({busy3, done3, pass3, a3, b3}), 16'({3'b011, 2'b11}));
    check("settle3_res", 16'({err3, mask3}), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
